// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory address/data plus the decode valid/ready handshake.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface instruction_fetch_unit_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instr;
    logic [15:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  instr,
        input  out_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, samples imem_data into a one-entry buffer offered to decode.
// Optional halt detection is enabled by defining HALT_DETECT_EN.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hE071
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            fetch_en,
    input  logic                            redirect_valid,
    input  logic [15:0]                     redirect_pc,
    output logic                            halted,
    instruction_fetch_unit_if.master        bus
);

`ifdef HALT_DETECT_EN
    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;
`else
    typedef enum logic [1:0] {FETCH, HOLD} state_t;
`endif

    state_t      state;
    logic [15:0] pc;
    logic        vld_p0;
    logic [15:0] instr_p0;
    logic [15:0] opc_p0;
    logic        halted_q;
    logic        load;
    logic        is_halt;
    logic        can_advance;

    // A load refills the buffer when it is empty or being drained this edge.
    assign load = fetch_en && can_advance && (!vld_p0 || bus.out_ready);

`ifdef HALT_DETECT_EN
    assign can_advance = (state != HALTED);
    assign is_halt     = (bus.imem_data == HALT_WORD);
`else
    logic [15:0] halt_word_unused;
    assign halt_word_unused = HALT_WORD;
    assign can_advance      = 1'b1;
    assign is_halt          = 1'b0;
`endif

    // Fetch stage -> output buffer (p0)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            vld_p0   <= 1'b0;
            instr_p0 <= 16'h0000;
            opc_p0   <= 16'h0000;
            halted_q <= 1'b0;
            state    <= FETCH;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            vld_p0   <= 1'b0;
            halted_q <= 1'b0;
            state    <= FETCH;
        end else if (load) begin
            instr_p0 <= bus.imem_data;
            opc_p0   <= pc;
            vld_p0   <= 1'b1;
            pc       <= pc + 16'd1;
`ifdef HALT_DETECT_EN
            if (is_halt) begin
                halted_q <= 1'b1;
                state    <= HALTED;
            end else begin
                state    <= FETCH;
            end
`else
            state    <= FETCH;
`endif
        end else begin
            if (vld_p0 && bus.out_ready) begin
                vld_p0 <= 1'b0;
            end
            if (can_advance) begin
                state <= (vld_p0 && !bus.out_ready) ? HOLD : FETCH;
            end
        end
    end

    assign bus.imem_addr = pc;
    assign bus.out_valid = vld_p0;
    assign bus.instr     = instr_p0;
    assign bus.out_pc    = opc_p0;

`ifdef HALT_DETECT_EN
    assign halted = halted_q;
`else
    logic halt_state_unused;
    assign halt_state_unused = halted_q ^ is_halt ^ (state == HOLD);
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized phase,
// compared every cycle against a buffer-level behavioural model.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_ready;
    logic        halted;

    logic [15:0] mem [0:65535];

    instruction_fetch_unit_if bus();

    assign bus.imem_data = mem[bus.imem_addr];
    assign bus.out_ready = out_ready;

    instruction_fetch_unit #(.RESET_PC(16'h0000), .HALT_WORD(16'hE071)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .bus            (bus)
    );

    always #5 clk = ~clk;

`ifdef HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    // Reference model: next address to fetch plus a one-slot buffer.
    logic [15:0] m_pc     = 16'h0000;
    logic        m_valid  = 1'b0;
    logic [15:0] m_instr  = 16'h0000;
    logic [15:0] m_opc    = 16'h0000;
    logic        m_halted = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit consumed;
        if (!rst_n) begin
            m_pc = 16'h0000; m_valid = 1'b0; m_instr = 16'h0000; m_opc = 16'h0000; m_halted = 1'b0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_valid = 1'b0; m_halted = 1'b0;
        end else begin
            consumed = m_valid && out_ready;
            if (fetch_en && !m_halted && (!m_valid || consumed)) begin
                m_instr = mem[m_pc];
                m_opc   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 16'd1;
                if (HALT_EN && m_instr == 16'hE071) m_halted = 1'b1;
            end else if (consumed) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("out_valid", {15'd0, bus.out_valid}, {15'd0, m_valid});
        chk("instr", bus.instr, m_instr);
        chk("out_pc", bus.out_pc, m_opc);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("halted", {15'd0, halted}, {15'd0, m_halted});
    endtask

    initial begin
        logic [15:0] t1 [0:3];
        logic [15:0] w;
        t1[0] = 16'h1111; t1[1] = 16'h2222; t1[2] = 16'h3333; t1[3] = 16'h4444;

        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w == 16'hE071) w = 16'h0000;
            mem[i] = w;
        end
        for (int i = 0; i < 4; i++) mem[i] = t1[i];
        mem[16'hFFFF] = 16'hAAAA;

        rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000; out_ready = 1'b0;
        tick(); tick();
        chk("reset_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("reset_pc", bus.imem_addr, 16'h0000);
        chk("reset_instr", bus.instr, 16'h0000);

        // Scenario 1: streaming at full rate
        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s1_instr", bus.instr, t1[i]);
            chk("s1_pc", bus.out_pc, 16'(i));
        end

        // Scenario 2: stall with 2222 presented
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick(); tick();
        chk("s2_present", bus.instr, 16'h2222);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_hold_instr", bus.instr, 16'h2222);
            chk("s2_hold_opc", bus.out_pc, 16'h0001);
            chk("s2_hold_pc", bus.imem_addr, 16'h0002);
        end
        out_ready = 1'b1; tick();
        chk("s2_resume", bus.instr, 16'h3333);

        // Scenario 3: redirect while stalled on pc=5
        tick(); tick(); tick();
        chk("s3_at5", bus.out_pc, 16'h0005);
        out_ready = 1'b0; tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0040; tick();
        chk("s3_flush", {15'd0, bus.out_valid}, 16'd0);
        redirect_valid = 1'b0; out_ready = 1'b1; tick();
        chk("s3_target", bus.instr, mem[16'h0040]);
        chk("s3_target_pc", bus.out_pc, 16'h0040);

        // Scenario 4: wrap-around from FFFF
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF; tick();
        redirect_valid = 1'b0; tick();
        chk("s4_ffff", bus.instr, 16'hAAAA);
        chk("s4_ffff_pc", bus.out_pc, 16'hFFFF);
        tick();
        chk("s4_wrap", bus.instr, 16'h1111);
        chk("s4_wrap_pc", bus.out_pc, 16'h0000);

        // Scenario 5: reset while valid
        out_ready = 1'b0; tick();
        rst_n = 1'b0; tick();
        chk("s5_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("s5_pc", bus.imem_addr, 16'h0000);
        rst_n = 1'b1; out_ready = 1'b1; tick();
        chk("s5_restart", bus.instr, 16'h1111);

        // Scenario 6: halt word at address 2
        mem[2] = 16'hE071;
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick(); tick(); tick();
        chk("s6_instr", bus.instr, 16'hE071);
        chk("s6_opc", bus.out_pc, 16'h0002);
        chk("s6_halted", {15'd0, halted}, {15'd0, HALT_EN});
        tick(); tick();
        chk("s6_pc_hold", bus.imem_addr, HALT_EN ? 16'h0003 : 16'h0005);
        redirect_valid = 1'b1; redirect_pc = 16'h0000; tick();
        chk("s6_clear", {15'd0, halted}, 16'd0);
        redirect_valid = 1'b0;

        // Randomized phase
        for (int c = 0; c < 600; c++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65530, 65535))
                                                          : 16'($urandom_range(0, 15));
            rst_n          = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
